// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: bundles the control FSM's datapath/ALU/memory/exception signals.
//
// Signals:
//   INSTR[31:0]       held instruction word (datapath -> controller)
//   ZF, OF            ALU zero / overflow flags (ALU -> controller)
//   MEM_RDY           memory transfer complete this cycle
//   TRAP_ACK          exception logic accepts the pending trap
//   ALU_OP[2:0]       ALU function select
//   ALU_SRC_A[1:0]    A operand mux: PC, rs, zero-extended shamt
//   ALU_SRC_B[1:0]    B operand mux: rt, 4, ext imm, sign-ext imm<<2
//   EXT_ZERO          immediate zero-extend (1) / sign-extend (0)
//   PC_WRITE, PC_SRC  PC load enable and source select
//   IR_WRITE          instruction register load enable
//   MEM_READ/WRITE    memory requests
//   REG_WRITE         register file write enable
//   REG_DST           write register select: rd (1) / rt (0)
//   MEM_TO_REG        writeback source: MDR (1) / ALUOut (0)
//   TRAP_VALID        trap pending
//   TRAP_CAUSE[1:0]   0 illegal, 1 overflow, 2 bus timeout
//   STATE[3:0]        current FSM state (debug)
//
// The master modport is the control FSM; the slave modport is the datapath side.

interface mc_ctrl_if;
   logic [31:0] INSTR;
   logic        ZF;
   logic        OF;
   logic        MEM_RDY;
   logic        TRAP_ACK;
   logic [2:0]  ALU_OP;
   logic [1:0]  ALU_SRC_A;
   logic [1:0]  ALU_SRC_B;
   logic        EXT_ZERO;
   logic        PC_WRITE;
   logic [1:0]  PC_SRC;
   logic        IR_WRITE;
   logic        MEM_READ;
   logic        MEM_WRITE;
   logic        REG_WRITE;
   logic        REG_DST;
   logic        MEM_TO_REG;
   logic        TRAP_VALID;
   logic [1:0]  TRAP_CAUSE;
   logic [3:0]  STATE;

   modport master (
      input  INSTR, ZF, OF, MEM_RDY, TRAP_ACK,
      output ALU_OP, ALU_SRC_A, ALU_SRC_B, EXT_ZERO, PC_WRITE, PC_SRC,
             IR_WRITE, MEM_READ, MEM_WRITE, REG_WRITE, REG_DST, MEM_TO_REG,
             TRAP_VALID, TRAP_CAUSE, STATE
   );

   modport slave (
      output INSTR, ZF, OF, MEM_RDY, TRAP_ACK,
      input  ALU_OP, ALU_SRC_A, ALU_SRC_B, EXT_ZERO, PC_WRITE, PC_SRC,
             IR_WRITE, MEM_READ, MEM_WRITE, REG_WRITE, REG_DST, MEM_TO_REG,
             TRAP_VALID, TRAP_CAUSE, STATE
   );
endinterface

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM.
// Decodes the held instruction and sequences FETCH/DECODE/EXECUTE/MEMORY/
// WRITEBACK, driving ALU selects, PC/IR/memory/register-file enables, and
// raising traps for illegal opcodes, memory bus timeouts and (optionally)
// arithmetic overflow.
//
// Ports:
//   CLK   rising-edge clock
//   RST   synchronous, active-high reset; all outputs read 0 while asserted
//   bus   mc_ctrl_if.master (see mc_ctrl_if.sv for the signal list)
//
// Parameters:
//   TIMEOUT  cycles to wait for MEM_RDY before a bus-timeout trap (0 = never)
//   CNT_W    wait counter width; TIMEOUT must be < 2**CNT_W
//
// Build option:
//   MC_OVF_TRAP_EN  when defined, add/sub/addi with OF=1 in ALU_WB suppress
//                   the register write and trap with cause 1.

module mc_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 8
) (
   input  logic      CLK,
   input  logic      RST,
   mc_ctrl_if.master bus
);

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_EXEC_R   = 4'd2;
   localparam logic [3:0] S_EXEC_I   = 4'd3;
   localparam logic [3:0] S_MEM_ADDR = 4'd4;
   localparam logic [3:0] S_MEM_RD   = 4'd5;
   localparam logic [3:0] S_MEM_WB   = 4'd6;
   localparam logic [3:0] S_MEM_WR   = 4'd7;
   localparam logic [3:0] S_ALU_WB   = 4'd8;
   localparam logic [3:0] S_BRANCH   = 4'd9;
   localparam logic [3:0] S_JUMP     = 4'd10;
   localparam logic [3:0] S_TRAP     = 4'd11;

   localparam logic [1:0] C_ILLEGAL  = 2'd0;
   localparam logic [1:0] C_OVF      = 2'd1;
   localparam logic [1:0] C_BUS      = 2'd2;

   localparam logic [CNT_W:0] TIMEOUT_V = (CNT_W+1)'(TIMEOUT);

   logic [3:0]       state, state_nxt;
   logic [1:0]       cause, cause_nxt;
   logic [CNT_W-1:0] wait_cnt;
   logic [5:0]       op, funct;
   logic             r_legal;
   logic [2:0]       r_alu_op;
   logic             in_wait;
   logic             timeout_hit;

   logic [2:0] alu_op;
   logic [1:0] src_a, src_b, pc_src, trap_cause;
   logic       ext_zero, pc_write, ir_write, mem_read, mem_write;
   logic       reg_write, reg_dst, mem_to_reg, trap_valid;
   logic       unused_ok;

   assign op    = bus.INSTR[31:26];
   assign funct = bus.INSTR[5:0];

`ifdef MC_OVF_TRAP_EN
   logic ovf_instr;
   assign ovf_instr = ((op == 6'h00) && ((funct == 6'h20) || (funct == 6'h22)))
                    || (op == 6'h08);
   assign unused_ok = ^bus.INSTR[25:6];
`else
   assign unused_ok = ^{bus.INSTR[25:6], bus.OF};
`endif

   // R-type funct decode: legality and ALU function
   always_comb begin
      r_legal  = 1'b1;
      r_alu_op = 3'd7;
      case (funct)
         6'h24:   r_alu_op = 3'd0;
         6'h25:   r_alu_op = 3'd1;
         6'h26:   r_alu_op = 3'd2;
         6'h27:   r_alu_op = 3'd3;
         6'h20:   r_alu_op = 3'd4;
         6'h22:   r_alu_op = 3'd5;
         6'h2A:   r_alu_op = 3'd6;
         6'h00:   r_alu_op = 3'd7;
         default: r_legal  = 1'b0;
      endcase
   end

   // The counter holds cycles already waited, so the trap fires in the cycle
   // where this wait would bring it to TIMEOUT; a MEM_RDY in that cycle wins.
   assign in_wait     = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
   assign timeout_hit = (TIMEOUT != 0) && !bus.MEM_RDY
                      && (({1'b0, wait_cnt} + (CNT_W+1)'(1)) == TIMEOUT_V);

   // Next state and per-state control outputs
   always_comb begin
      state_nxt  = state;
      cause_nxt  = cause;
      alu_op     = 3'd0;
      src_a      = 2'd0;
      src_b      = 2'd0;
      ext_zero   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'd0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      trap_valid = 1'b0;
      trap_cause = 2'd0;
      case (state)
         S_FETCH: begin
            mem_read = 1'b1;
            src_b    = 2'd1;
            alu_op   = 3'd4;
            if (bus.MEM_RDY) begin
               ir_write  = 1'b1;
               pc_write  = 1'b1;
               state_nxt = S_DECODE;
            end else if (timeout_hit) begin
               state_nxt = S_TRAP;
               cause_nxt = C_BUS;
            end
         end
         S_DECODE: begin
            src_b  = 2'd3;
            alu_op = 3'd4;
            case (op)
               6'h00:                      state_nxt = r_legal ? S_EXEC_R : S_TRAP;
               6'h08, 6'h0C, 6'h0D, 6'h0E: state_nxt = S_EXEC_I;
               6'h23, 6'h2B:               state_nxt = S_MEM_ADDR;
               6'h04:                      state_nxt = S_BRANCH;
               6'h02:                      state_nxt = S_JUMP;
               default:                    state_nxt = S_TRAP;
            endcase
            if (state_nxt == S_TRAP) begin
               cause_nxt = C_ILLEGAL;
            end
         end
         S_EXEC_R: begin
            src_a     = (funct == 6'h00) ? 2'd2 : 2'd1;
            alu_op    = r_alu_op;
            state_nxt = S_ALU_WB;
         end
         S_EXEC_I: begin
            src_a = 2'd1;
            src_b = 2'd2;
            case (op)
               6'h08:   alu_op = 3'd4;
               6'h0C:   begin alu_op = 3'd0; ext_zero = 1'b1; end
               6'h0D:   begin alu_op = 3'd1; ext_zero = 1'b1; end
               6'h0E:   begin alu_op = 3'd2; ext_zero = 1'b1; end
               default: alu_op = 3'd0;
            endcase
            state_nxt = S_ALU_WB;
         end
         S_MEM_ADDR: begin
            src_a     = 2'd1;
            src_b     = 2'd2;
            alu_op    = 3'd4;
            state_nxt = (op == 6'h23) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            mem_read = 1'b1;
            if (bus.MEM_RDY) begin
               state_nxt = S_MEM_WB;
            end else if (timeout_hit) begin
               state_nxt = S_TRAP;
               cause_nxt = C_BUS;
            end
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            state_nxt  = S_FETCH;
         end
         S_MEM_WR: begin
            mem_write = 1'b1;
            if (bus.MEM_RDY) begin
               state_nxt = S_FETCH;
            end else if (timeout_hit) begin
               state_nxt = S_TRAP;
               cause_nxt = C_BUS;
            end
         end
         S_ALU_WB: begin
            reg_write = 1'b1;
            reg_dst   = (op == 6'h00);
            state_nxt = S_FETCH;
`ifdef MC_OVF_TRAP_EN
            if (bus.OF && ovf_instr) begin
               reg_write = 1'b0;
               state_nxt = S_TRAP;
               cause_nxt = C_OVF;
            end
`endif
         end
         S_BRANCH: begin
            src_a     = 2'd1;
            alu_op    = 3'd5;
            pc_src    = 2'd1;
            pc_write  = bus.ZF;
            state_nxt = S_FETCH;
         end
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_src    = 2'd2;
            state_nxt = S_FETCH;
         end
         S_TRAP: begin
            trap_valid = 1'b1;
            trap_cause = cause;
            if (bus.TRAP_ACK) begin
               state_nxt = S_FETCH;
            end
         end
         default: state_nxt = S_FETCH;
      endcase
   end

   // State, trap cause and wait counter; the counter restarts on any state
   // change so every FETCH/MEM_RD/MEM_WR visit starts from zero.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= S_FETCH;
         cause    <= C_ILLEGAL;
         wait_cnt <= '0;
      end else begin
         state <= state_nxt;
         cause <= cause_nxt;
         if (state_nxt != state) begin
            wait_cnt <= '0;
         end else if (in_wait && !bus.MEM_RDY) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
         end
      end
   end

   // Reset forces every output low so nothing is written in a reset cycle
   assign bus.ALU_OP     = RST ? 3'd0 : alu_op;
   assign bus.ALU_SRC_A  = RST ? 2'd0 : src_a;
   assign bus.ALU_SRC_B  = RST ? 2'd0 : src_b;
   assign bus.EXT_ZERO   = RST ? 1'b0 : ext_zero;
   assign bus.PC_WRITE   = RST ? 1'b0 : pc_write;
   assign bus.PC_SRC     = RST ? 2'd0 : pc_src;
   assign bus.IR_WRITE   = RST ? 1'b0 : ir_write;
   assign bus.MEM_READ   = RST ? 1'b0 : mem_read;
   assign bus.MEM_WRITE  = RST ? 1'b0 : mem_write;
   assign bus.REG_WRITE  = RST ? 1'b0 : reg_write;
   assign bus.REG_DST    = RST ? 1'b0 : reg_dst;
   assign bus.MEM_TO_REG = RST ? 1'b0 : mem_to_reg;
   assign bus.TRAP_VALID = RST ? 1'b0 : trap_valid;
   assign bus.TRAP_CAUSE = RST ? 2'd0 : trap_cause;
   assign bus.STATE      = RST ? 4'd0 : state;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed, table-driven bench for mc_ctrl (TIMEOUT=16).
// Each vector is one clock cycle: inputs applied after the rising edge,
// all outputs compared on the falling edge against hand-computed values.

module tb_mc_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   mc_ctrl_if bus ();

   mc_ctrl #(.TIMEOUT(16), .CNT_W(8)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

`ifdef MC_OVF_TRAP_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   localparam logic [31:0] I_ADD  = 32'h00851020;
   localparam logic [31:0] I_ORI  = 32'h34A5000F;
   localparam logic [31:0] I_ADDI = 32'h20A5FFFF;
   localparam logic [31:0] I_SLL  = 32'h00052080;
   localparam logic [31:0] I_NOR  = 32'h00A43027;
   localparam logic [31:0] I_LW   = 32'h8C880004;
   localparam logic [31:0] I_SW   = 32'hAC880004;
   localparam logic [31:0] I_BEQ  = 32'h10850003;
   localparam logic [31:0] I_J    = 32'h08000010;
   localparam logic [31:0] I_ILL  = 32'hFC000000;

   typedef struct packed {
      logic [3:0] state;
      logic [2:0] alu_op;
      logic [1:0] src_a;
      logic [1:0] src_b;
      logic       ext_zero;
      logic       pc_write;
      logic [1:0] pc_src;
      logic       ir_write;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       trap_valid;
      logic [1:0] trap_cause;
   } outs_t;

   typedef struct {
      string       name;
      logic        rst;
      logic [31:0] instr;
      logic        zf;
      logic        of;
      logic        rdy;
      logic        ack;
      outs_t       exp;
   } vec_t;

   vec_t vecs[$];
   int   n_applied    = 0;
   int   n_miscompare = 0;

   outs_t zero, f_rdy, f_wait, dec, wb_r, wb_i, mem_addr, ex_add, ex_ori, ex_addi;
   outs_t mem_rd, mem_wr, trap_ill, trap_bus, trap_ovf;

   function automatic outs_t mk(int st, int aop, int sa, int sb, int ez, int pcw, int pcs,
                                int irw, int mr, int mw, int rw, int rd, int m2r,
                                int tv, int tc);
      outs_t o;
      o.state      = 4'(st);
      o.alu_op     = 3'(aop);
      o.src_a      = 2'(sa);
      o.src_b      = 2'(sb);
      o.ext_zero   = 1'(ez);
      o.pc_write   = 1'(pcw);
      o.pc_src     = 2'(pcs);
      o.ir_write   = 1'(irw);
      o.mem_read   = 1'(mr);
      o.mem_write  = 1'(mw);
      o.reg_write  = 1'(rw);
      o.reg_dst    = 1'(rd);
      o.mem_to_reg = 1'(m2r);
      o.trap_valid = 1'(tv);
      o.trap_cause = 2'(tc);
      return o;
   endfunction

   task automatic addVec(input string name, input logic r, input logic [31:0] i,
                         input logic z, input logic o, input logic rd, input logic a,
                         input outs_t e);
      vec_t v;
      v.name  = name;
      v.rst   = r;
      v.instr = i;
      v.zf    = z;
      v.of    = o;
      v.rdy   = rd;
      v.ack   = a;
      v.exp   = e;
      vecs.push_back(v);
   endtask

   task automatic applyStimulus(input logic r, input logic [31:0] i, input logic z,
                                input logic o, input logic rd, input logic a);
      rst          = r;
      bus.INSTR    = i;
      bus.ZF       = z;
      bus.OF       = o;
      bus.MEM_RDY  = rd;
      bus.TRAP_ACK = a;
   endtask

   task automatic checkOutput(input string name, input outs_t e);
      outs_t got;
      got = {bus.STATE, bus.ALU_OP, bus.ALU_SRC_A, bus.ALU_SRC_B, bus.EXT_ZERO,
             bus.PC_WRITE, bus.PC_SRC, bus.IR_WRITE, bus.MEM_READ, bus.MEM_WRITE,
             bus.REG_WRITE, bus.REG_DST, bus.MEM_TO_REG, bus.TRAP_VALID, bus.TRAP_CAUSE};
      n_applied++;
      if (got !== e) begin
         n_miscompare++;
         $display("[TB] FAIL %s: got state=%0d outs=%h, expected state=%0d outs=%h",
                  name, got.state, got, e.state, e);
      end
   endtask

   task automatic step(input string name, input logic r, input logic [31:0] i,
                       input logic z, input logic o, input logic rd, input logic a,
                       input outs_t e);
      applyStimulus(r, i, z, o, rd, a);
      @(negedge clk);
      checkOutput(name, e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      applyStimulus(1'b1, I_ADD, 1'b0, 1'b0, 1'b0, 1'b0);

      //            st aop sa sb ez pcw pcs irw mr mw rw rd m2r tv tc
      zero     = '0;
      f_rdy    = mk(0, 4, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
      f_wait   = mk(0, 4, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      dec      = mk(1, 4, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      ex_add   = mk(2, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      ex_ori   = mk(3, 1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      ex_addi  = mk(3, 4, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      mem_addr = mk(4, 4, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      mem_rd   = mk(5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      mem_wr   = mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      wb_r     = mk(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      wb_i     = mk(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      trap_ill = mk(11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      trap_ovf = mk(11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      trap_bus = mk(11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);

      // reset with active-looking inputs: everything must read 0
      addVec("reset0", 1, I_ADD, 1, 1, 1, 1, zero);
      addVec("reset1", 1, I_ADD, 1, 1, 1, 1, zero);
      // add: 4 cycles
      addVec("add_fetch",  0, I_ADD, 0, 0, 1, 0, f_rdy);
      addVec("add_decode", 0, I_ADD, 0, 0, 1, 0, dec);
      addVec("add_exec",   0, I_ADD, 0, 0, 1, 0, ex_add);
      addVec("add_wb",     0, I_ADD, 0, 0, 1, 0, wb_r);
      // ori: zero-extended immediate
      addVec("ori_fetch",  0, I_ORI, 0, 0, 1, 0, f_rdy);
      addVec("ori_decode", 0, I_ORI, 0, 0, 1, 0, dec);
      addVec("ori_exec",   0, I_ORI, 0, 0, 1, 0, ex_ori);
      addVec("ori_wb",     0, I_ORI, 0, 0, 1, 0, wb_i);
      // addi: sign-extended immediate
      addVec("addi_fetch",  0, I_ADDI, 0, 0, 1, 0, f_rdy);
      addVec("addi_decode", 0, I_ADDI, 0, 0, 1, 0, dec);
      addVec("addi_exec",   0, I_ADDI, 0, 0, 1, 0, ex_addi);
      addVec("addi_wb",     0, I_ADDI, 0, 0, 1, 0, wb_i);
      // sll: shamt on A, op 7
      addVec("sll_fetch",  0, I_SLL, 0, 0, 1, 0, f_rdy);
      addVec("sll_decode", 0, I_SLL, 0, 0, 1, 0, dec);
      addVec("sll_exec",   0, I_SLL, 0, 0, 1, 0, mk(2, 7, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      addVec("sll_wb",     0, I_SLL, 0, 0, 1, 0, wb_r);
      // nor
      addVec("nor_fetch",  0, I_NOR, 0, 0, 1, 0, f_rdy);
      addVec("nor_decode", 0, I_NOR, 0, 0, 1, 0, dec);
      addVec("nor_exec",   0, I_NOR, 0, 0, 1, 0, mk(2, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      addVec("nor_wb",     0, I_NOR, 0, 0, 1, 0, wb_r);
      // lw with three wait cycles in MEM_RD: 8 cycles total
      addVec("lw_fetch",   0, I_LW, 0, 0, 1, 0, f_rdy);
      addVec("lw_decode",  0, I_LW, 0, 0, 1, 0, dec);
      addVec("lw_addr",    0, I_LW, 0, 0, 0, 0, mem_addr);
      addVec("lw_rd_w0",   0, I_LW, 0, 0, 0, 0, mem_rd);
      addVec("lw_rd_w1",   0, I_LW, 0, 0, 0, 0, mem_rd);
      addVec("lw_rd_w2",   0, I_LW, 0, 0, 0, 0, mem_rd);
      addVec("lw_rd_done", 0, I_LW, 0, 0, 1, 0, mem_rd);
      addVec("lw_wb",      0, I_LW, 0, 0, 1, 0, mk(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
      // sw with one wait cycle
      addVec("sw_fetch",   0, I_SW, 0, 0, 1, 0, f_rdy);
      addVec("sw_decode",  0, I_SW, 0, 0, 1, 0, dec);
      addVec("sw_addr",    0, I_SW, 0, 0, 1, 0, mem_addr);
      addVec("sw_wr_w0",   0, I_SW, 0, 0, 0, 0, mem_wr);
      addVec("sw_wr_done", 0, I_SW, 0, 0, 1, 0, mem_wr);
      // beq taken / not taken
      addVec("beq1_fetch",  0, I_BEQ, 1, 0, 1, 0, f_rdy);
      addVec("beq1_decode", 0, I_BEQ, 1, 0, 1, 0, dec);
      addVec("beq1_branch", 0, I_BEQ, 1, 0, 1, 0, mk(9, 5, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      addVec("beq0_fetch",  0, I_BEQ, 0, 0, 1, 0, f_rdy);
      addVec("beq0_decode", 0, I_BEQ, 0, 0, 1, 0, dec);
      addVec("beq0_branch", 0, I_BEQ, 0, 0, 1, 0, mk(9, 5, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      // j
      addVec("j_fetch",  0, I_J, 0, 0, 1, 0, f_rdy);
      addVec("j_decode", 0, I_J, 0, 0, 1, 0, dec);
      addVec("j_jump",   0, I_J, 0, 0, 1, 0, mk(10, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
      // add with overflow
      addVec("addof_fetch",  0, I_ADD, 0, 1, 1, 0, f_rdy);
      addVec("addof_decode", 0, I_ADD, 0, 1, 1, 0, dec);
      addVec("addof_exec",   0, I_ADD, 0, 1, 1, 0, ex_add);
      addVec("addof_wb",     0, I_ADD, 0, 1, 1, 0,
             mk(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, OVF_EN ? 0 : 1, 1, 0, 0, 0));
      addVec("addof_after",  0, I_ADD, 0, 1, 0, 1, OVF_EN ? trap_ovf : f_wait);
      // addi with overflow
      addVec("addiof_fetch",  0, I_ADDI, 0, 1, 1, 0, f_rdy);
      addVec("addiof_decode", 0, I_ADDI, 0, 1, 1, 0, dec);
      addVec("addiof_exec",   0, I_ADDI, 0, 1, 1, 0, ex_addi);
      addVec("addiof_wb",     0, I_ADDI, 0, 1, 1, 0,
             mk(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, OVF_EN ? 0 : 1, 0, 0, 0, 0));
      addVec("addiof_after",  0, I_ADDI, 0, 1, 0, 1, OVF_EN ? trap_ovf : f_wait);
      // ori ignores OF in every build
      addVec("oriof_fetch",  0, I_ORI, 0, 1, 1, 0, f_rdy);
      addVec("oriof_decode", 0, I_ORI, 0, 1, 1, 0, dec);
      addVec("oriof_exec",   0, I_ORI, 0, 1, 1, 0, ex_ori);
      addVec("oriof_wb",     0, I_ORI, 0, 1, 1, 0, wb_i);
      // illegal opcode: trap cause 0 held until ack
      addVec("ill_fetch",   0, I_ILL, 0, 0, 1, 0, f_rdy);
      addVec("ill_decode",  0, I_ILL, 0, 0, 1, 0, dec);
      addVec("ill_trap0",   0, I_ILL, 0, 0, 1, 0, trap_ill);
      addVec("ill_trap1",   0, I_ILL, 0, 0, 1, 0, trap_ill);
      addVec("ill_trapack", 0, I_ILL, 0, 0, 1, 1, trap_ill);

      $display("[TB] applying %0d table vectors", vecs.size());
      foreach (vecs[k]) begin
         step(vecs[k].name, vecs[k].rst, vecs[k].instr, vecs[k].zf, vecs[k].of,
              vecs[k].rdy, vecs[k].ack, vecs[k].exp);
      end

      // MEM_RDY arriving in the last allowed cycle wins over the timeout
      for (int k = 0; k < 15; k++) begin
         step("rdywin_wait", 0, I_J, 0, 0, 0, 0, f_wait);
      end
      step("rdywin_fetch",  0, I_J, 0, 0, 1, 0, f_rdy);
      step("rdywin_decode", 0, I_J, 0, 0, 1, 0, dec);
      step("rdywin_jump",   0, I_J, 0, 0, 1, 0, mk(10, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0));

      // 16 cycles without MEM_RDY in FETCH -> bus timeout trap
      for (int k = 0; k < 16; k++) begin
         step("timeout_wait", 0, I_J, 0, 0, 0, 0, f_wait);
      end
      step("timeout_trap",    0, I_J, 0, 0, 0, 0, trap_bus);
      step("timeout_trapack", 0, I_J, 0, 0, 0, 1, trap_bus);

      // reset in the middle of an add abandons it
      step("rstmid_fetch",  0, I_ADD, 0, 0, 1, 0, f_rdy);
      step("rstmid_decode", 0, I_ADD, 0, 0, 1, 0, dec);
      step("rstmid_exec",   0, I_ADD, 0, 0, 1, 0, ex_add);
      step("rstmid_rst0",   1, I_ADD, 1, 1, 1, 1, zero);
      step("rstmid_rst1",   1, I_ADD, 1, 1, 1, 1, zero);
      step("rstmid_after",  0, I_ADD, 0, 0, 0, 0, f_wait);

      $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompare);
      $finish;
   end

endmodule
